// File: rtl/fcap_pkg.sv
// Shared types and default geometry for the frame capture controller.
// Optional double-buffering is enabled with the DOUBLE_BUF_EN macro.
package fcap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        CAPTURE,
        DONE
    } fcap_state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_WIN_W    = 256;
    localparam int DEF_WIN_H    = 256;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/vsync_edge_det.sv
// Registers the synchronised camera vsync and flags its edges.
// Falling edge marks start of frame, rising edge marks end of frame.
module vsync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic cam_vsync,
    output logic sof,
    output logic eof
);

    logic vsync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= cam_vsync;
        end
    end

    assign sof = vsync_q & ~cam_vsync;
    assign eof = ~vsync_q & cam_vsync;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Crops the camera pixel stream into the frame buffer write port.
// Define DOUBLE_BUF_EN to add wr_bank/rd_bank ping-pong buffering.
module frame_capture_ctrl
    import fcap_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int WIN_W    = DEF_WIN_W,
    parameter int WIN_H    = DEF_WIN_H,
    parameter int ADDR_W   = $clog2(WIN_W) + $clog2(WIN_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cam_vsync,
    input  logic              pix_valid,
    input  logic [15:0]       pix_data,
    input  logic              freeze,
    input  logic              frame_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              frame_ready,
    output logic              frame_err,
    output logic              capturing
`ifdef DOUBLE_BUF_EN
    ,
    output logic              wr_bank,
    output logic              rd_bank
`endif
);

    localparam int HW  = $clog2(H_ACTIVE);
    localparam int VW  = $clog2(V_ACTIVE);
    localparam int WHW = $clog2(WIN_W);
    localparam int WVW = $clog2(WIN_H);

    localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE - 1);
    localparam logic [HW-1:0] H_WIN  = HW'(WIN_W);
    localparam logic [VW-1:0] V_WIN  = VW'(WIN_H);

    fcap_state_t   state;
    fcap_state_t   state_nxt;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          sof;
    logic          eof;
    logic          start;
    logic          cap_pix;
    logic          in_win;
    logic          complete;
    logic          abort;

    vsync_edge_det u_edge (
        .clk       (clk),
        .rst       (rst),
        .cam_vsync (cam_vsync),
        .sof       (sof),
        .eof       (eof)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!freeze) state_nxt = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (freeze)   state_nxt = IDLE;
                else if (sof) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (eof)           state_nxt = WAIT_SOF;
                else if (complete) state_nxt = DONE;
            end
            DONE: begin
                if (freeze) begin
                    state_nxt = IDLE;
`ifdef DOUBLE_BUF_EN
                end else begin
                    state_nxt = WAIT_SOF;
`else
                end else if (!frame_ready) begin
                    state_nxt = WAIT_SOF;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A vsync edge wins over a coincident pixel strobe.
    always_comb begin
        capturing = (state == CAPTURE);
        start     = (state == WAIT_SOF) && !freeze && sof;
        cap_pix   = (state == CAPTURE) && pix_valid && !sof && !eof;
        in_win    = (h < H_WIN) && (v < V_WIN);
        complete  = cap_pix && (h == H_LAST) && (v == V_LAST);
        abort     = (state == CAPTURE) && eof;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h           <= '0;
            v           <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            frame_ready <= 1'b0;
        end else begin
            wr_en      <= cap_pix && in_win;
            frame_done <= complete;
            frame_err  <= abort;
            if (start) begin
                h <= '0;
                v <= '0;
            end else if (cap_pix && !complete) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= v + 1'b1;
                end else begin
                    h <= h + 1'b1;
                end
            end
            if (cap_pix && in_win) begin
                wr_addr <= {v[WVW-1:0], h[WHW-1:0]};
                wr_data <= pix_data;
            end
            if (complete) begin
                frame_ready <= 1'b1;
            end else if (frame_ack) begin
                frame_ready <= 1'b0;
            end
        end
    end

`ifdef DOUBLE_BUF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else if (complete) begin
            rd_bank <= wr_bank;
            wr_bank <= ~wr_bank;
        end
    end
`endif

endmodule
